// File: rtl/beehive_vr_pkg.sv
// Shared VR replica types: prepare message header, replica state, log entry
// header and the prepare-stage reason codes / FSM states.
// The log_entry_hdr layout is the contract between the prepare log writer and
// the commit engine. Fields are packed MSB-first in declaration order.
package beehive_vr_pkg;

  localparam int LOG_DEPTH_W = 4;
  localparam int VIEW_W      = 32;
  localparam int OP_W        = 32;
  localparam int LEN_W       = 16;

  typedef enum logic [1:0] {
    LOG_STATE_EMPTY    = 2'd0,
    LOG_STATE_PREPARED = 2'd1,
    LOG_STATE_COMMITED = 2'd2
  } log_entry_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op_num;
    logic [VIEW_W-1:0] view;
    logic [LEN_W-1:0]  entry_len;       // bytes, header line included
    log_entry_state_e  log_entry_state;
  } log_entry_hdr;

  localparam int LOG_ENTRY_HDR_W = $bits(log_entry_hdr);

  typedef struct packed {
    logic [VIEW_W-1:0] view;
    logic [OP_W-1:0]   opnum;
    logic [OP_W-1:0]   commit_num;
    logic [LEN_W-1:0]  payload_len;     // bytes, always > 0
  } prepare_msg_hdr;

  localparam int PREPARE_MSG_HDR_W = $bits(prepare_msg_hdr);

  typedef struct packed {
    logic [VIEW_W-1:0]      curr_view;
    logic [OP_W-1:0]        last_op;
    logic [OP_W-1:0]        last_commit;
    logic [LOG_DEPTH_W-1:0] log_head;
    logic [LOG_DEPTH_W-1:0] log_tail;
  } vr_state;

  typedef enum logic [1:0] {
    PREP_OK         = 2'd0,
    PREP_STALE_VIEW = 2'd1,
    PREP_BAD_OPNUM  = 2'd2,
    PREP_LOG_FULL   = 2'd3
  } prep_fail_e;

  typedef enum logic [3:0] {
    PREP_IDLE,
    PREP_RD_REQ,
    PREP_RD_RESP,
    PREP_CHECK,
    PREP_WR_HDR,
    PREP_WR_DATA,
    PREP_DRAIN,
    PREP_WR_STATE,
    PREP_DONE
  } prep_state_e;

endpackage

// File: rtl/prepare_log_writer_ctrl.sv
// Control FSM for the prepare log writer: sequences header accept, vr_state
// read, check, log-line writes (or payload drain), state write-back and the
// done response. Drives all val/rdy handshakes and the datapath strobes.
// Ports: manager hdr/data/done handshakes, vr_state rd req/resp and wr
// handshakes, log memory write handshake, datapath strobes (hdr_ld, st_ld,
// chk_en, addr_inc, sel_hdr) and check result (chk_fail, fail_reason).
module prepare_log_writer_ctrl
  import beehive_vr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hdr_val,
  output logic       hdr_rdy,
  input  logic       data_val,
  input  logic       data_last,
  output logic       data_rdy,
  output logic       rd_req_val,
  input  logic       rd_req_rdy,
  input  logic       rd_resp_val,
  output logic       rd_resp_rdy,
  output logic       st_wr_val,
  input  logic       st_wr_rdy,
  output logic       mem_wr_val,
  input  logic       mem_wr_rdy,
  output logic       done_val,
  input  logic       done_rdy,
  output logic       done_ok,
  output logic [1:0] done_reason,
  input  logic       chk_fail,
  input  prep_fail_e fail_reason,
  output logic       hdr_ld,
  output logic       st_ld,
  output logic       chk_en,
  output logic       addr_inc,
  output logic       sel_hdr
);

  prep_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= PREP_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PREP_IDLE:     if (hdr_val)     state_d = PREP_RD_REQ;
      PREP_RD_REQ:   if (rd_req_rdy)  state_d = PREP_RD_RESP;
      PREP_RD_RESP:  if (rd_resp_val) state_d = PREP_CHECK;
      PREP_CHECK:    state_d = chk_fail ? PREP_DRAIN : PREP_WR_HDR;
      PREP_WR_HDR:   if (mem_wr_rdy)  state_d = PREP_WR_DATA;
      PREP_WR_DATA:  if (data_val && mem_wr_rdy && data_last) state_d = PREP_WR_STATE;
      PREP_DRAIN:    if (data_val && data_last) state_d = PREP_DONE;
      PREP_WR_STATE: if (st_wr_rdy)   state_d = PREP_DONE;
      PREP_DONE:     if (done_rdy)    state_d = PREP_IDLE;
      default:       state_d = PREP_IDLE;
    endcase
  end

  // Outputs are forced low while rst is high so nothing is offered or
  // accepted during reset, regardless of the state register's old value.
  always_comb begin
    hdr_rdy     = 1'b0;
    data_rdy    = 1'b0;
    rd_req_val  = 1'b0;
    rd_resp_rdy = 1'b0;
    st_wr_val   = 1'b0;
    mem_wr_val  = 1'b0;
    done_val    = 1'b0;
    done_ok     = 1'b0;
    done_reason = 2'd0;
    hdr_ld      = 1'b0;
    st_ld       = 1'b0;
    chk_en      = 1'b0;
    addr_inc    = 1'b0;
    sel_hdr     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        PREP_IDLE: begin
          hdr_rdy = 1'b1;
          hdr_ld  = hdr_val;
        end
        PREP_RD_REQ:  rd_req_val = 1'b1;
        PREP_RD_RESP: begin
          rd_resp_rdy = 1'b1;
          st_ld       = rd_resp_val;
        end
        PREP_CHECK:   chk_en = 1'b1;
        PREP_WR_HDR: begin
          mem_wr_val = 1'b1;
          sel_hdr    = 1'b1;
          addr_inc   = mem_wr_rdy;
        end
        PREP_WR_DATA: begin
          // Payload beats flow straight into log memory.
          mem_wr_val = data_val;
          data_rdy   = mem_wr_rdy;
          addr_inc   = data_val & mem_wr_rdy;
        end
        PREP_DRAIN:    data_rdy  = 1'b1;
        PREP_WR_STATE: st_wr_val = 1'b1;
        PREP_DONE: begin
          done_val    = 1'b1;
          done_ok     = (fail_reason == PREP_OK);
          done_reason = fail_reason;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/prepare_log_writer_datap.sv
// Datapath for the prepare log writer: latched header and vr_state, log
// address counter, view/opnum (and optionally free-space) checks, log entry
// header-line build and the state write-back value.
// Optional feature macro: PREP_LOG_FULL_CHECK_EN enables the free-space check.
// Ports: clk, hdr_in/st_in/data_in, strobes from ctrl, chk_fail/fail_reason
// back to ctrl, log memory addr/data and state write data.
module prepare_log_writer_datap
  import beehive_vr_pkg::*;
#(
  parameter int NOC_DATA_W = -1
) (
  input  logic                   clk,
  input  prepare_msg_hdr         hdr_in,
  input  vr_state                st_in,
  input  logic [NOC_DATA_W-1:0]  data_in,
  input  logic                   hdr_ld,
  input  logic                   st_ld,
  input  logic                   chk_en,
  input  logic                   addr_inc,
  input  logic                   sel_hdr,
  output logic                   chk_fail,
  output prep_fail_e             fail_reason,
  output logic [LOG_DEPTH_W-1:0] mem_wr_addr,
  output logic [NOC_DATA_W-1:0]  mem_wr_data,
  output vr_state                st_wr_data
);

  localparam int NOC_BYTES = NOC_DATA_W / 8;

  prepare_msg_hdr         hdr_q, hdr_d;
  vr_state                st_q, st_d;
  logic [LOG_DEPTH_W-1:0] addr_q, addr_d;
  prep_fail_e             reason_q, reason_d;
  prep_fail_e             fail_c;
  log_entry_hdr           ent_c;
  logic [NOC_DATA_W-1:0]  hdr_line_c;
  logic                   unused_commit_num;

  // commit_num is carried by the message but not consumed at this stage.
  assign unused_commit_num = ^hdr_q.commit_num;

`ifdef PREP_LOG_FULL_CHECK_EN
  logic [LOG_DEPTH_W-1:0] free_c;
  logic [31:0]            lines_c;
  logic [31:0]            need_c;

  // One slot is kept empty so head == tail always means an empty log.
  assign free_c  = st_q.log_head - st_q.log_tail - LOG_DEPTH_W'(1);
  assign lines_c = (32'(hdr_q.payload_len) + 32'(NOC_BYTES - 1)) / 32'(NOC_BYTES);
  assign need_c  = lines_c + 32'd1;
`endif

  always_comb begin
    fail_c = PREP_OK;
    if (hdr_q.view != st_q.curr_view)
      fail_c = PREP_STALE_VIEW;
    else if (hdr_q.opnum != st_q.last_op + 32'd1)
      fail_c = PREP_BAD_OPNUM;
`ifdef PREP_LOG_FULL_CHECK_EN
    else if (need_c > 32'(free_c))
      fail_c = PREP_LOG_FULL;
`endif
  end

  assign chk_fail    = (fail_c != PREP_OK);
  assign fail_reason = reason_q;

  always_comb begin
    hdr_d    = hdr_q;
    st_d     = st_q;
    addr_d   = addr_q;
    reason_d = reason_q;
    if (hdr_ld) hdr_d = hdr_in;
    if (st_ld)  st_d  = st_in;
    if (chk_en) begin
      addr_d   = st_q.log_tail;
      reason_d = fail_c;
    end else if (addr_inc) begin
      addr_d = addr_q + LOG_DEPTH_W'(1);   // wraps with the log
    end
  end

  always_ff @(posedge clk) begin
    hdr_q    <= hdr_d;
    st_q     <= st_d;
    addr_q   <= addr_d;
    reason_q <= reason_d;
  end

  always_comb begin
    ent_c.op_num          = hdr_q.opnum;
    ent_c.view            = hdr_q.view;
    ent_c.entry_len       = LEN_W'(NOC_BYTES) + hdr_q.payload_len;
    ent_c.log_entry_state = LOG_STATE_PREPARED;
    hdr_line_c = '0;
    hdr_line_c[NOC_DATA_W-1 -: LOG_ENTRY_HDR_W] = ent_c;
  end

  assign mem_wr_addr = addr_q;
  assign mem_wr_data = sel_hdr ? hdr_line_c : data_in;

  // After the last beat addr_q points one past the entry: the new tail.
  always_comb begin
    st_wr_data          = st_q;
    st_wr_data.last_op  = hdr_q.opnum;
    st_wr_data.log_tail = addr_q;
  end

endmodule

// File: rtl/prepare_log_writer.sv
// Prepare log writer: validates a VR Prepare against vr_state, appends a
// PREPARED log entry (header line + payload lines) at log_tail and writes
// back vr_state with last_op and log_tail advanced; one done per header.
// Optional feature macro: PREP_LOG_FULL_CHECK_EN (reject with reason 3 when
// the entry does not fit between log_tail and log_head).
// Ports: manager prep hdr/data in, done out; vr_state read req/resp and
// write; log memory write.
module prepare_log_writer
  import beehive_vr_pkg::*;
#(
  parameter int NOC_DATA_W = -1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   manage_prep_hdr_val,
  input  prepare_msg_hdr         manage_prep_hdr,
  output logic                   prep_manage_hdr_rdy,
  input  logic                   manage_prep_data_val,
  input  logic [NOC_DATA_W-1:0]  manage_prep_data,
  input  logic                   manage_prep_data_last,
  output logic                   prep_manage_data_rdy,
  output logic                   prep_vr_state_rd_req_val,
  input  logic                   vr_state_prep_rd_req_rdy,
  input  logic                   vr_state_prep_rd_resp_val,
  input  vr_state                vr_state_prep_rd_resp_data,
  output logic                   prep_vr_state_rd_resp_rdy,
  output logic                   prep_vr_state_wr_val,
  output vr_state                prep_vr_state_wr_data,
  input  logic                   vr_state_prep_wr_rdy,
  output logic                   prep_log_mem_wr_val,
  output logic [LOG_DEPTH_W-1:0] prep_log_mem_wr_addr,
  output logic [NOC_DATA_W-1:0]  prep_log_mem_wr_data,
  input  logic                   log_mem_prep_wr_rdy,
  output logic                   prep_manage_done_val,
  output logic                   prep_manage_done_ok,
  output logic [1:0]             prep_manage_done_reason,
  input  logic                   manage_prep_done_rdy
);

  logic       hdr_ld, st_ld, chk_en, addr_inc, sel_hdr, chk_fail;
  prep_fail_e fail_reason;

  prepare_log_writer_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .hdr_val     (manage_prep_hdr_val),
    .hdr_rdy     (prep_manage_hdr_rdy),
    .data_val    (manage_prep_data_val),
    .data_last   (manage_prep_data_last),
    .data_rdy    (prep_manage_data_rdy),
    .rd_req_val  (prep_vr_state_rd_req_val),
    .rd_req_rdy  (vr_state_prep_rd_req_rdy),
    .rd_resp_val (vr_state_prep_rd_resp_val),
    .rd_resp_rdy (prep_vr_state_rd_resp_rdy),
    .st_wr_val   (prep_vr_state_wr_val),
    .st_wr_rdy   (vr_state_prep_wr_rdy),
    .mem_wr_val  (prep_log_mem_wr_val),
    .mem_wr_rdy  (log_mem_prep_wr_rdy),
    .done_val    (prep_manage_done_val),
    .done_rdy    (manage_prep_done_rdy),
    .done_ok     (prep_manage_done_ok),
    .done_reason (prep_manage_done_reason),
    .chk_fail    (chk_fail),
    .fail_reason (fail_reason),
    .hdr_ld      (hdr_ld),
    .st_ld       (st_ld),
    .chk_en      (chk_en),
    .addr_inc    (addr_inc),
    .sel_hdr     (sel_hdr)
  );

  prepare_log_writer_datap #(.NOC_DATA_W(NOC_DATA_W)) u_datap (
    .clk         (clk),
    .hdr_in      (manage_prep_hdr),
    .st_in       (vr_state_prep_rd_resp_data),
    .data_in     (manage_prep_data),
    .hdr_ld      (hdr_ld),
    .st_ld       (st_ld),
    .chk_en      (chk_en),
    .addr_inc    (addr_inc),
    .sel_hdr     (sel_hdr),
    .chk_fail    (chk_fail),
    .fail_reason (fail_reason),
    .mem_wr_addr (prep_log_mem_wr_addr),
    .mem_wr_data (prep_log_mem_wr_data),
    .st_wr_data  (prep_vr_state_wr_data)
  );

endmodule

// File: tb/tb_prepare_log_writer.sv
module tb_prepare_log_writer;
  import beehive_vr_pkg::*;

  localparam int DW = 512;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   manage_prep_hdr_val = 1'b0;
  prepare_msg_hdr         manage_prep_hdr = '0;
  logic                   prep_manage_hdr_rdy;
  logic                   manage_prep_data_val = 1'b0;
  logic [DW-1:0]          manage_prep_data = '0;
  logic                   manage_prep_data_last = 1'b0;
  logic                   prep_manage_data_rdy;
  logic                   prep_vr_state_rd_req_val;
  logic                   vr_state_prep_rd_req_rdy = 1'b1;
  logic                   vr_state_prep_rd_resp_val = 1'b0;
  vr_state                resp_state = '0;
  logic                   prep_vr_state_rd_resp_rdy;
  logic                   prep_vr_state_wr_val;
  vr_state                prep_vr_state_wr_data;
  logic                   vr_state_prep_wr_rdy = 1'b1;
  logic                   prep_log_mem_wr_val;
  logic [LOG_DEPTH_W-1:0] prep_log_mem_wr_addr;
  logic [DW-1:0]          prep_log_mem_wr_data;
  logic                   log_mem_prep_wr_rdy = 1'b1;
  logic                   prep_manage_done_val;
  logic                   prep_manage_done_ok;
  logic [1:0]             prep_manage_done_reason;
  logic                   manage_prep_done_rdy = 1'b1;

  prepare_log_writer #(.NOC_DATA_W(DW)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .manage_prep_hdr_val        (manage_prep_hdr_val),
    .manage_prep_hdr            (manage_prep_hdr),
    .prep_manage_hdr_rdy        (prep_manage_hdr_rdy),
    .manage_prep_data_val       (manage_prep_data_val),
    .manage_prep_data           (manage_prep_data),
    .manage_prep_data_last      (manage_prep_data_last),
    .prep_manage_data_rdy       (prep_manage_data_rdy),
    .prep_vr_state_rd_req_val   (prep_vr_state_rd_req_val),
    .vr_state_prep_rd_req_rdy   (vr_state_prep_rd_req_rdy),
    .vr_state_prep_rd_resp_val  (vr_state_prep_rd_resp_val),
    .vr_state_prep_rd_resp_data (resp_state),
    .prep_vr_state_rd_resp_rdy  (prep_vr_state_rd_resp_rdy),
    .prep_vr_state_wr_val       (prep_vr_state_wr_val),
    .prep_vr_state_wr_data      (prep_vr_state_wr_data),
    .vr_state_prep_wr_rdy       (vr_state_prep_wr_rdy),
    .prep_log_mem_wr_val        (prep_log_mem_wr_val),
    .prep_log_mem_wr_addr       (prep_log_mem_wr_addr),
    .prep_log_mem_wr_data       (prep_log_mem_wr_data),
    .log_mem_prep_wr_rdy        (log_mem_prep_wr_rdy),
    .prep_manage_done_val       (prep_manage_done_val),
    .prep_manage_done_ok        (prep_manage_done_ok),
    .prep_manage_done_reason    (prep_manage_done_reason),
    .manage_prep_done_rdy       (manage_prep_done_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int hdr_cyc = 0;
  bit stall_en = 1'b0;

  logic [LOG_DEPTH_W-1:0] wr_addr_q[$];
  logic [DW-1:0]          wr_data_q[$];
  int                     wr_cyc_q[$];
  vr_state                st_wr_q[$];
  logic                   done_ok_q[$];
  logic [1:0]             done_rsn_q[$];
  int                     done_cyc_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Hand-built log entry header line: op, view, len, PREPARED, zero pad.
  function automatic logic [DW-1:0] hl(input logic [31:0] op, input logic [31:0] view,
                                       input logic [15:0] len);
    return {op, view, len, 2'b01, 430'd0};
  endfunction

  function automatic logic [DW-1:0] pat(input int t, input int i);
    return {16{32'hC0DE_0000 ^ 32'(t * 256 + i)}};
  endfunction

  function automatic prepare_msg_hdr mk_hdr(input int view, input int op, input int len);
    prepare_msg_hdr h;
    h.view = 32'(view); h.opnum = 32'(op); h.commit_num = 32'd5; h.payload_len = 16'(len);
    return h;
  endfunction

  function automatic vr_state mk_st(input int view, input int lop, input int head, input int tail);
    vr_state s;
    s.curr_view = 32'(view); s.last_op = 32'(lop); s.last_commit = 32'd5;
    s.log_head = LOG_DEPTH_W'(head); s.log_tail = LOG_DEPTH_W'(tail);
    return s;
  endfunction

  function automatic logic [DW-1:0] ga(input int i);
    return (i < wr_addr_q.size()) ? DW'(wr_addr_q[i]) : '1;
  endfunction
  function automatic logic [DW-1:0] gd(input int i);
    return (i < wr_data_q.size()) ? wr_data_q[i] : '1;
  endfunction
  function automatic logic [DW-1:0] gs(input int i);
    return (i < st_wr_q.size()) ? DW'(st_wr_q[i]) : '1;
  endfunction
  function automatic logic [DW-1:0] gr(input int i);
    return (i < done_rsn_q.size()) ? DW'(done_rsn_q[i]) : '1;
  endfunction
  function automatic logic [DW-1:0] go(input int i);
    return (i < done_ok_q.size()) ? DW'(done_ok_q[i]) : '1;
  endfunction

  // vr_state responder and random ready stalls; all changes at negedge.
  bit pend = 1'b0;
  bit rsp_taken = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_taken) begin vr_state_prep_rd_resp_val = 1'b0; rsp_taken = 1'b0; end
      if (rst) begin pend = 1'b0; vr_state_prep_rd_resp_val = 1'b0; end
      vr_state_prep_rd_req_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      vr_state_prep_wr_rdy     = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      log_mem_prep_wr_rdy      = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      manage_prep_done_rdy     = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend && !vr_state_prep_rd_resp_val && (!stall_en || $urandom_range(0, 1) == 1)) begin
        vr_state_prep_rd_resp_val = 1'b1;
        pend = 1'b0;
      end
      #2;
      if (prep_vr_state_rd_req_val && vr_state_prep_rd_req_rdy) pend = 1'b1;
      if (vr_state_prep_rd_resp_val && prep_vr_state_rd_resp_rdy) rsp_taken = 1'b1;
    end
  end

  // Transfer monitor: val&rdy seen here completes at the following posedge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (prep_log_mem_wr_val && log_mem_prep_wr_rdy) begin
        wr_addr_q.push_back(prep_log_mem_wr_addr);
        wr_data_q.push_back(prep_log_mem_wr_data);
        wr_cyc_q.push_back(cyc);
      end
      if (prep_vr_state_wr_val && vr_state_prep_wr_rdy) st_wr_q.push_back(prep_vr_state_wr_data);
      if (prep_manage_done_val && manage_prep_done_rdy) begin
        done_ok_q.push_back(prep_manage_done_ok);
        done_rsn_q.push_back(prep_manage_done_reason);
        done_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic clear_q();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    st_wr_q.delete(); done_ok_q.delete(); done_rsn_q.delete(); done_cyc_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic drive_hdr(input prepare_msg_hdr h);
    int n = 0;
    manage_prep_hdr = h;
    manage_prep_hdr_val = 1'b1;
    #2;
    while (!prep_manage_hdr_rdy && n < 200) begin @(negedge clk); #2; n++; end
    chk("hdr_accept_in_time", DW'(n < 200), DW'(1));
    hdr_cyc = cyc;
    @(negedge clk);
    manage_prep_hdr_val = 1'b0;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input bit last, input bit gap);
    int n = 0;
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    manage_prep_data = d;
    manage_prep_data_last = last;
    manage_prep_data_val = 1'b1;
    #2;
    while (!prep_manage_data_rdy && n < 200) begin @(negedge clk); #2; n++; end
    chk("beat_accept_in_time", DW'(n < 200), DW'(1));
    @(negedge clk);
    manage_prep_data_val = 1'b0;
    manage_prep_data_last = 1'b0;
  endtask

  task automatic run_msg(input int t, input prepare_msg_hdr h, input vr_state s, input int nl);
    int n = 0;
    clear_q();
    resp_state = s;
    @(negedge clk);
    drive_hdr(h);
    for (int i = 0; i < nl; i++) drive_beat(pat(t, i), (i == nl - 1), stall_en);
    while (done_ok_q.size() == 0 && n < 400) begin @(negedge clk); n++; end
    chk("done_in_time", DW'(n < 400), DW'(1));
  endtask

  // Checks a successful append: header at base, nl payload lines after it.
  task automatic exp_ok(input string t, input int tid, input int base, input logic [DW-1:0] line0,
                        input int nl, input vr_state exp_st);
    chk({t, "_wr_count"}, DW'(wr_addr_q.size()), DW'(nl + 1));
    chk({t, "_hdr_addr"}, ga(0), DW'(base));
    chk({t, "_hdr_line"}, gd(0), line0);
    for (int i = 0; i < nl; i++) begin
      chk({t, "_data_addr"}, ga(i + 1), DW'((base + 1 + i) % 16));
      chk({t, "_data_line"}, gd(i + 1), pat(tid, i));
    end
    chk({t, "_st_count"}, DW'(st_wr_q.size()), DW'(1));
    chk({t, "_st_data"}, gs(0), DW'(exp_st));
    chk({t, "_done_ok"}, go(0), DW'(1));
    chk({t, "_done_reason"}, gr(0), DW'(0));
  endtask

  task automatic exp_fail(input string t, input int reason);
    chk({t, "_wr_count"}, DW'(wr_addr_q.size()), DW'(0));
    chk({t, "_st_count"}, DW'(st_wr_q.size()), DW'(0));
    chk({t, "_done_ok"}, go(0), DW'(0));
    chk({t, "_done_reason"}, gr(0), DW'(reason));
  endtask

  task automatic chk_quiet(input string t, input bit exp_hdr_rdy);
    chk({t, "_hdr_rdy"}, DW'(prep_manage_hdr_rdy), DW'(exp_hdr_rdy));
    chk({t, "_data_rdy"}, DW'(prep_manage_data_rdy), DW'(0));
    chk({t, "_rd_req_val"}, DW'(prep_vr_state_rd_req_val), DW'(0));
    chk({t, "_rd_resp_rdy"}, DW'(prep_vr_state_rd_resp_rdy), DW'(0));
    chk({t, "_st_wr_val"}, DW'(prep_vr_state_wr_val), DW'(0));
    chk({t, "_mem_wr_val"}, DW'(prep_log_mem_wr_val), DW'(0));
    chk({t, "_done_val"}, DW'(prep_manage_done_val), DW'(0));
    chk({t, "_done_ok"}, DW'(prep_manage_done_ok), DW'(0));
    chk({t, "_done_reason"}, DW'(prep_manage_done_reason), DW'(0));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk_quiet("rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_quiet("idle", 1'b1);

    // Basic append: 100 bytes -> 2 lines, entry_len 164, tail 10 -> 13
    run_msg(1, mk_hdr(3, 8, 100), mk_st(3, 7, 2, 10), 2);
    exp_ok("t1", 1, 10, hl(8, 3, 164), 2, mk_st(3, 8, 2, 13));
    chk("t1_first_wr_latency", DW'(wr_cyc_q.size() > 0 ? wr_cyc_q[0] - hdr_cyc : -1), DW'(4));
    chk("t1_done_latency", DW'(done_cyc_q.size() > 0 ? done_cyc_q[0] - hdr_cyc : -1), DW'(8));

    // Stale view: payload drained, nothing written
    run_msg(2, mk_hdr(3, 8, 100), mk_st(4, 7, 2, 10), 2);
    exp_fail("t2", 1);

    // Bad opnum
    run_msg(3, mk_hdr(3, 9, 100), mk_st(3, 7, 2, 10), 2);
    exp_fail("t3", 2);

    // Entry straddles the address wrap: 15, 0, 1 -> tail 2
    run_msg(4, mk_hdr(3, 8, 128), mk_st(3, 7, 8, 15), 2);
    exp_ok("t4", 4, 15, hl(8, 3, 192), 2, mk_st(3, 8, 8, 2));

    // head 3, tail 1: free 1 but the entry needs 3 lines
    run_msg(5, mk_hdr(3, 8, 65), mk_st(3, 7, 3, 1), 2);
`ifdef PREP_LOG_FULL_CHECK_EN
    exp_fail("t5", 3);
`else
    exp_ok("t5", 5, 1, hl(8, 3, 129), 2, mk_st(3, 8, 3, 4));
`endif

    // Random stalls on every interface: same result as t1
    stall_en = 1'b1;
    run_msg(1, mk_hdr(3, 8, 100), mk_st(3, 7, 2, 10), 2);
    exp_ok("t6", 1, 10, hl(8, 3, 164), 2, mk_st(3, 8, 2, 13));
    stall_en = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset during WR_DATA (3-line message, one beat taken)
    clear_q();
    resp_state = mk_st(3, 7, 2, 10);
    drive_hdr(mk_hdr(3, 8, 150));
    drive_beat(pat(7, 0), 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk_quiet("t7_rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_quiet("t7_idle", 1'b1);
    chk("t7_wr_count", DW'(wr_addr_q.size()), DW'(2));
    chk("t7_st_count", DW'(st_wr_q.size()), DW'(0));
    chk("t7_done_count", DW'(done_ok_q.size()), DW'(0));

    // Following message lands at the untouched tail
    run_msg(8, mk_hdr(3, 8, 100), mk_st(3, 7, 2, 10), 2);
    exp_ok("t8", 8, 10, hl(8, 3, 164), 2, mk_st(3, 8, 2, 13));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
